// File: rtl/frame_buffer_2d_if.sv
// Pixel access bus between the ingest writer / window-fetch reader and frame_buffer_2d.
interface frame_buffer_2d_if #(
  parameter int PIXW  = 1,
  parameter int ADDRW = 8
);
  // Handshake: wr_en/rd_en/clear_start are single-cycle strobes sampled on every
  // rising edge with no backpressure. A request is taken only while busy=0; during
  // busy it is silently ignored. rd_valid qualifies data_out for exactly one cycle
  // per accepted read, and oob_err flags a dropped out-of-range request one cycle later.
  logic [ADDRW-1:0] x_in;
  logic [ADDRW-1:0] y_in;
  logic [PIXW-1:0]  data_in;
  logic             wr_en;
  logic             rd_en;
  logic             clear_start;
  logic [PIXW-1:0]  data_out;
  logic             rd_valid;
  logic             oob_err;
  logic             busy;

  modport master (
    output x_in, y_in, data_in, wr_en, rd_en, clear_start,
    input  data_out, rd_valid, oob_err, busy
  );

  modport slave (
    input  x_in, y_in, data_in, wr_en, rd_en, clear_start,
    output data_out, rd_valid, oob_err, busy
  );
endinterface

// File: rtl/frame_buffer_2d.sv
// Single-port 2-D frame buffer: (x,y) addressing, bounds check, pipelined reads and a
// hardware clear sequencer. Define FB_CLEAR_ON_RESET_EN to auto-clear after every reset.
module frame_buffer_2d #(
  parameter int              IMWIDTH    = 240,
  parameter int              IMHEIGHT   = 180,
  parameter int              PIXW       = 1,
  parameter int              ADDRW      = 8,
  parameter int              RD_LATENCY = 4,
  parameter logic [PIXW-1:0] CLEAR_VAL  = '0
) (
  input  logic               clk,
  input  logic               reset,
  frame_buffer_2d_if.slave   bus,
  output logic               dbg_state_o
);

  localparam int DEPTH = IMWIDTH * IMHEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef FB_CLEAR_ON_RESET_EN
  localparam logic BOOT_CLEAR = 1'b1;
`else
  localparam logic BOOT_CLEAR = 1'b0;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            boot_q, boot_d;
  logic            oob_q, oob_d;
  logic            rd_go;
  logic            in_bounds;
  logic [AW-1:0]   flat_addr;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [PIXW-1:0] mem_wdata;

  logic [PIXW-1:0]       mem_q  [DEPTH];
  logic [PIXW-1:0]       pipe_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] vld_q;

  assign in_bounds = (32'(bus.x_in) < IMWIDTH) && (32'(bus.y_in) < IMHEIGHT);
  // Only consumed when in bounds, so AW bits always hold the full product.
  assign flat_addr = AW'(bus.y_in) * AW'(IMWIDTH) + AW'(bus.x_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= '0;
      boot_q    <= BOOT_CLEAR;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      boot_q    <= boot_d;
      oob_q     <= oob_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    boot_d    = 1'b0;
    oob_d     = 1'b0;
    rd_go     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = flat_addr;
    mem_wdata = bus.data_in;
    case (state_q)
      S_IDLE: begin
        clr_cnt_d = '0;
        // A clear request (or the post-reset auto clear) swallows any access this cycle.
        if (bus.clear_start || boot_q) begin
          state_d = S_CLEAR;
        end else if (bus.wr_en) begin
          if (in_bounds) mem_we = 1'b1;
          else           oob_d  = 1'b1;
        end else if (bus.rd_en) begin
          if (in_bounds) rd_go = 1'b1;
          else           oob_d = 1'b1;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = CLEAR_VAL;
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Stage 0 is the RAM output register; the rest are plain delay stages that never stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q <= '{default: '0};
      vld_q  <= '0;
    end else begin
      vld_q[0] <= rd_go;
      if (rd_go) pipe_q[0] <= mem_q[flat_addr];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.data_out = pipe_q[RD_LATENCY-1];
  assign bus.rd_valid = vld_q[RD_LATENCY-1];
  assign bus.oob_err  = oob_q;
  assign bus.busy     = (state_q == S_CLEAR);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_frame_buffer_2d.sv
// Self-checking bench for frame_buffer_2d: reference pixel model plus scoreboard queues
// for read data/latency and oob_err pulses.
module tb_frame_buffer_2d;

  localparam int IMWIDTH    = 240;
  localparam int IMHEIGHT   = 180;
  localparam int PIXW       = 1;
  localparam int ADDRW      = 8;
  localparam int RD_LATENCY = 4;
  localparam int DEPTH      = IMWIDTH * IMHEIGHT;
  localparam int CLR_BOUND  = 50000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic dbg_state;

  int edge_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [PIXW-1:0] exp_q[$];
  int              due_q[$];
  int              oob_due_q[$];
  logic [PIXW-1:0] mem_model [DEPTH];
  bit              model_busy = 1'b0;

  frame_buffer_2d_if #(.PIXW(PIXW), .ADDRW(ADDRW)) bus ();

  frame_buffer_2d #(
    .IMWIDTH   (IMWIDTH),
    .IMHEIGHT  (IMHEIGHT),
    .PIXW      (PIXW),
    .ADDRW     (ADDRW),
    .RD_LATENCY(RD_LATENCY),
    .CLEAR_VAL ('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      bit want_rd;
      bit want_oob;
      want_rd = (due_q.size() > 0) && (due_q[0] == edge_cnt);
      if (want_rd || bus.rd_valid) begin
        check("rd_valid", 32'(bus.rd_valid), 32'(want_rd));
        if (want_rd) begin
          if (bus.rd_valid) check("rd_data", 32'(bus.data_out), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      want_oob = (oob_due_q.size() > 0) && (oob_due_q[0] == edge_cnt);
      if (want_oob || bus.oob_err) begin
        check("oob_err", 32'(bus.oob_err), 32'(want_oob));
        if (want_oob) void'(oob_due_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit wr, input bit rd, input int x, input int y,
                       input logic [PIXW-1:0] d);
    int acc;
    int flat;
    bit inb;
    bus.wr_en       = wr;
    bus.rd_en       = rd;
    bus.x_in        = ADDRW'(x);
    bus.y_in        = ADDRW'(y);
    bus.data_in     = d;
    bus.clear_start = 1'b0;
    acc  = edge_cnt + 1;
    inb  = (x < IMWIDTH) && (y < IMHEIGHT);
    flat = y * IMWIDTH + x;
    if (!model_busy) begin
      if (wr) begin
        if (inb) mem_model[flat] = d;
        else     oob_due_q.push_back(acc);
      end else if (rd) begin
        if (inb) begin
          exp_q.push_back(mem_model[flat]);
          due_q.push_back(acc + RD_LATENCY - 1);
        end else begin
          oob_due_q.push_back(acc);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, '0);
  endtask

  task automatic clear_pulse();
    bus.wr_en       = 1'b0;
    bus.rd_en       = 1'b0;
    bus.clear_start = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_start = 1'b0;
    model_busy      = 1'b1;
  endtask

  // Runs ignored noise while busy; returns number of cycles busy was seen high.
  task automatic run_clear(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < CLR_BOUND) begin
      cycles++;
      if (cycles % 997 == 3)      drive(1'b0, 1'b1, int'($urandom_range(IMWIDTH-1)), 2, '0);
      else if (cycles % 991 == 7) drive(1'b1, 1'b0, 3, 2, 1'b1);
      else if (cycles % 983 == 11) drive(1'b1, 1'b1, 240, 0, 1'b1);
      else idle(1);
    end
    model_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    int rx, ry, op;
    bus.x_in = '0; bus.y_in = '0; bus.data_in = '0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clear_start = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(bus.data_out), 32'(0));
    check("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
    check("rst_oob_err",  32'(bus.oob_err),  32'(0));
    check("rst_busy",     32'(bus.busy),     32'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
`ifdef FB_CLEAR_ON_RESET_EN
    model_busy = 1'b1;
    check("boot_busy", 32'(bus.busy), 32'(1));
    run_clear(cyc);
    check("boot_busy_cycles", cyc, DEPTH);
`endif

    // Single write then read at (3,2)
    drive(1'b1, 1'b0, 3, 2, 1'b1);
    drive(1'b0, 1'b1, 3, 2, '0);
    idle(RD_LATENCY + 2);

    // Eight back-to-back reads of distinct addresses
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 17*i + 5, 23*i + 1, PIXW'(i % 3 == 0));
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 17*i + 5, 23*i + 1, '0);
    idle(RD_LATENCY + 2);

    // Out-of-range accesses must not touch memory or produce data
    drive(1'b1, 1'b0, 0, 1, 1'b0);
    drive(1'b1, 1'b0, 240, 0, 1'b1);
    drive(1'b0, 1'b1, 0, 180, '0);
    drive(1'b0, 1'b0, 255, 255, 1'b1);
    drive(1'b1, 1'b1, 240, 5, 1'b1);
    drive(1'b0, 1'b1, 0, 1, '0);
    idle(RD_LATENCY + 2);

    // Simultaneous write and read: write wins
    drive(1'b1, 1'b0, 10, 10, 1'b0);
    drive(1'b1, 1'b1, 10, 10, 1'b1);
    idle(RD_LATENCY + 1);
    drive(1'b0, 1'b1, 10, 10, '0);
    idle(RD_LATENCY + 2);

    // Read-after-write on consecutive cycles, plus frame corners
    drive(1'b1, 1'b0, 5, 5, 1'b0);
    drive(1'b1, 1'b0, 5, 5, 1'b1);
    drive(1'b0, 1'b1, 5, 5, '0);
    drive(1'b1, 1'b0, 5, 5, 1'b0);
    drive(1'b0, 1'b1, 5, 5, '0);
    drive(1'b1, 1'b0, 0, 0, 1'b1);
    drive(1'b1, 1'b0, IMWIDTH-1, IMHEIGHT-1, 1'b1);
    drive(1'b0, 1'b1, IMWIDTH-1, IMHEIGHT-1, '0);
    drive(1'b0, 1'b1, 0, 0, '0);
    idle(RD_LATENCY + 2);

    // Random traffic over a pre-written window, with occasional out-of-range hits
    for (int x = 0; x < 16; x++)
      for (int y = 40; y < 44; y++) drive(1'b1, 1'b0, x, y, PIXW'($urandom_range(1)));
    for (int i = 0; i < 200; i++) begin
      rx = int'($urandom_range(15));
      ry = 40 + int'($urandom_range(3));
      op = int'($urandom_range(9));
      if (op == 9)      rx = IMWIDTH + int'($urandom_range(15));
      if (op < 4)       drive(1'b1, 1'b0, rx, ry, PIXW'($urandom_range(1)));
      else if (op < 8)  drive(1'b0, 1'b1, rx, ry, '0);
      else if (op == 8) idle(1);
      else              drive(op[0], ~op[0], rx, ry, 1'b1);
    end
    idle(RD_LATENCY + 2);

    // Full-frame clear; a read issued just before it must still drain
    drive(1'b0, 1'b1, 3, 2, '0);
    clear_pulse();
    run_clear(cyc);
    check("clear_busy_cycles", cyc, DEPTH);
    check("busy_after_clear", 32'(bus.busy), 32'(0));
    drive(1'b0, 1'b1, 3, 2, '0);
    drive(1'b0, 1'b1, 0, 0, '0);
    drive(1'b0, 1'b1, IMWIDTH-1, IMHEIGHT-1, '0);
    drive(1'b0, 1'b1, 10, 10, '0);
    drive(1'b0, 1'b1, 5, 5, '0);
    for (int i = 0; i < 200; i++)
      drive(1'b0, 1'b1, int'($urandom_range(IMWIDTH-1)), int'($urandom_range(IMHEIGHT-1)), '0);
    idle(RD_LATENCY + 2);

    // Reset 100 cycles into a clear
    drive(1'b1, 1'b0, 7, 7, 1'b1);
    clear_pulse();
    idle(99);
    check("busy_mid_clear", 32'(bus.busy), 32'(1));
    exp_q.delete();
    due_q.delete();
    oob_due_q.delete();
    reset = 1'b0;
    #1;
    check("abort_busy",     32'(bus.busy),     32'(0));
    check("abort_rd_valid", 32'(bus.rd_valid), 32'(0));
    check("abort_oob_err",  32'(bus.oob_err),  32'(0));
    model_busy = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
`ifdef FB_CLEAR_ON_RESET_EN
    check("reclear_busy", 32'(bus.busy), 32'(1));
`else
    check("no_reclear_busy", 32'(bus.busy), 32'(0));
    idle(3);
    check("still_idle_busy", 32'(bus.busy), 32'(0));
    drive(1'b1, 1'b0, 7, 8, 1'b1);
    drive(1'b0, 1'b1, 7, 8, '0);
    idle(RD_LATENCY + 2);
`endif

    // Drain anything still outstanding, bounded
    cyc = 0;
    while ((due_q.size() > 0 || oob_due_q.size() > 0) && cyc < 20) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    check("drain_rd",  due_q.size(),     0);
    check("drain_oob", oob_due_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
